// File: rtl/scan_mux.sv
// scan_mux: registered channel multiplexer with manual select and a timed
// round-robin scan mode. Each scanned channel is held for DWELL enabled
// cycles. A one-cycle wrap pulse accompanies the last sample of each full pass.

module scan_mux #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DWELL    = 1,
    localparam int unsigned SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          dout,
    output logic                      dout_valid,
    output logic [SELW-1:0]           ch_out,
    output logic                      wrap
);

    typedef enum logic {
        StMan,
        StScan
    } state_e;

    localparam logic [SELW-1:0] PTR_LAST   = SELW'(CHANNELS - 1);
    localparam logic [7:0]      DWELL_LAST = 8'(DWELL - 1);

    state_e            r_state;
    logic [SELW-1:0]   r_ptr;
    logic [7:0]        r_dcnt;
    logic [WIDTH-1:0]  r_dout;
    logic [SELW-1:0]   r_ch;
    logic              r_valid;
    logic              r_wrap;

    logic [WIDTH-1:0]  w_man_data;
    logic [WIDTH-1:0]  w_scan_data;
    logic              w_sel_ok;
    logic              w_ptr_last;
    logic              w_dwell_last;

    // Select the manual and scan channels; an out-of-range sel matches nothing.
    always_comb begin
        w_man_data  = '0;
        w_scan_data = '0;
        w_sel_ok    = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (sel == SELW'(k)) begin
                w_man_data = din[k*WIDTH +: WIDTH];
                w_sel_ok   = 1'b1;
            end
            if (r_ptr == SELW'(k)) begin
                w_scan_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Position of the scan pointer within the current pass.
    always_comb begin
        w_ptr_last   = (r_ptr == PTR_LAST);
        w_dwell_last = (r_dcnt == DWELL_LAST);
    end

    // Mode FSM with registered outputs. mode=0 always performs the manual
    // action immediately; entering scan from manual costs one idle cycle so the
    // first scan sample is always channel 0 with a fresh dwell count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StMan;
            r_ptr   <= '0;
            r_dcnt  <= '0;
            r_dout  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (!en) begin
                // Freeze position and data; only the strobes drop.
                r_valid <= 1'b0;
            end else if (!mode) begin
                r_state <= StMan;
                if (w_sel_ok) begin
                    r_dout  <= w_man_data;
                    r_ch    <= sel;
                    r_valid <= 1'b1;
                end else begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end
            end else if (r_state == StMan) begin
                r_state <= StScan;
                r_ptr   <= '0;
                r_dcnt  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_dout  <= w_scan_data;
                r_ch    <= r_ptr;
                r_valid <= 1'b1;
                r_wrap  <= w_ptr_last && w_dwell_last;
                if (w_dwell_last) begin
                    r_dcnt <= '0;
                    r_ptr  <= w_ptr_last ? '0 : (r_ptr + SELW'(1));
                end else begin
                    r_dcnt <= r_dcnt + 8'd1;
                end
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        dout       = r_dout;
        dout_valid = r_valid;
        ch_out     = r_ch;
        wrap       = r_wrap;
    end

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: four parameterisations share control inputs; each is
// compared every cycle against a pass-position reference model, plus directed
// scenarios with fixed expected values.

module tb_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, mode;
    logic [1:0]  sel;
    logic [31:0] din_a, din_b;
    logic [3:0]  din_m;
    logic [11:0] din_r;

    logic [7:0]  dout_a, dout_b;
    logic        dout_m;
    logic [3:0]  dout_r;
    logic        valid_a, valid_b, valid_m, valid_r;
    logic [1:0]  ch_a, ch_b, ch_m, ch_r;
    logic        wrap_a, wrap_b, wrap_m, wrap_r;

    scan_mux #(.WIDTH(8), .CHANNELS(4), .DWELL(1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .din(din_a),
        .dout(dout_a), .dout_valid(valid_a), .ch_out(ch_a), .wrap(wrap_a));
    scan_mux #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .din(din_b),
        .dout(dout_b), .dout_valid(valid_b), .ch_out(ch_b), .wrap(wrap_b));
    scan_mux #(.WIDTH(1), .CHANNELS(4), .DWELL(1)) u_m (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .din(din_m),
        .dout(dout_m), .dout_valid(valid_m), .ch_out(ch_m), .wrap(wrap_m));
    scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(2)) u_r (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .din(din_r),
        .dout(dout_r), .dout_valid(valid_r), .ch_out(ch_r), .wrap(wrap_r));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: k is the sample index within the current scan pass.
    typedef struct {
        bit scan;
        int k;
        int dout;
        int ch;
        bit valid;
        bit wrap;
    } mdl_t;

    mdl_t  mdl [4];
    int    p_w [4] = '{8, 8, 1, 4};
    int    p_c [4] = '{4, 4, 4, 3};
    int    p_d [4] = '{1, 3, 1, 2};
    string nm  [4] = '{"a", "b", "m", "r"};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int chan_val(input logic [63:0] dv, input int w, input int c);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return int'((dv >> (c * w)) & mask);
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int w, input int c, input int d,
                                      input bit e, input bit md, input int s,
                                      input logic [63:0] dv);
        mdl_t n;
        int   chn;
        n = m;
        n.wrap = 1'b0;
        if (!e) begin
            n.valid = 1'b0;
        end else if (!md) begin
            n.scan = 1'b0;
            if (s < c) begin
                n.dout  = chan_val(dv, w, s);
                n.ch    = s;
                n.valid = 1'b1;
            end else begin
                n.dout  = 0;
                n.valid = 1'b0;
            end
        end else if (!m.scan) begin
            n.scan  = 1'b1;
            n.k     = 0;
            n.valid = 1'b0;
        end else begin
            chn     = (m.k / d) % c;
            n.dout  = chan_val(dv, w, chn);
            n.ch    = chn;
            n.valid = 1'b1;
            n.wrap  = (m.k == c * d - 1);
            n.k     = (m.k + 1) % (c * d);
        end
        return n;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 4; i++) begin
            mdl[i] = '{scan: 1'b0, k: 0, dout: 0, ch: 0, valid: 1'b0, wrap: 1'b0};
        end
    endtask

    task automatic compare_all();
        logic [31:0] g_dout [4];
        logic [31:0] g_ch   [4];
        logic [31:0] g_v    [4];
        logic [31:0] g_w    [4];
        g_dout[0] = 32'(dout_a); g_ch[0] = 32'(ch_a); g_v[0] = 32'(valid_a); g_w[0] = 32'(wrap_a);
        g_dout[1] = 32'(dout_b); g_ch[1] = 32'(ch_b); g_v[1] = 32'(valid_b); g_w[1] = 32'(wrap_b);
        g_dout[2] = 32'(dout_m); g_ch[2] = 32'(ch_m); g_v[2] = 32'(valid_m); g_w[2] = 32'(wrap_m);
        g_dout[3] = 32'(dout_r); g_ch[3] = 32'(ch_r); g_v[3] = 32'(valid_r); g_w[3] = 32'(wrap_r);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s.dout", nm[i]), g_dout[i], 32'(mdl[i].dout));
            check($sformatf("%s.ch", nm[i]), g_ch[i], 32'(mdl[i].ch));
            check($sformatf("%s.valid", nm[i]), g_v[i], 32'(mdl[i].valid));
            check($sformatf("%s.wrap", nm[i]), g_w[i], 32'(mdl[i].wrap));
        end
    endtask

    // One clock edge: capture inputs, advance models, compare just after the edge.
    task automatic tick();
        logic [63:0] dv [4];
        bit e, md;
        int s;
        dv[0] = 64'(din_a);
        dv[1] = 64'(din_b);
        dv[2] = 64'(din_m);
        dv[3] = 64'(din_r);
        e  = en;
        md = mode;
        s  = int'(sel);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            mdl[i] = mdl_step(mdl[i], p_w[i], p_c[i], p_d[i], e, md, s, dv[i]);
        end
        #1;
        compare_all();
    endtask

    // Pulse reset between edges; caller must be just after an edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        mdl_reset();
        #1 compare_all();
        #1 rst_n = 1'b1;
    endtask

    logic [7:0]  seq [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    logic [31:0] rnd;

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        sel   = 2'd0;
        din_a = '0;
        din_b = '0;
        din_m = '0;
        din_r = '0;
        mdl_reset();
        #1 compare_all();
        check("reset.a.dout", 32'(dout_a), 32'h0);
        #6 rst_n = 1'b1;

        // Manual select on the 1-bit instance.
        en    = 1'b1;
        din_m = 4'b0100;
        din_a = 32'hD3C2B1A0;
        din_b = 32'hD3C2B1A0;
        din_r = 12'h321;
        sel   = 2'd2;
        tick();
        check("man.dout_sel2", 32'(dout_m), 32'd1);
        check("man.ch_sel2", 32'(ch_m), 32'd2);
        check("man.valid_sel2", 32'(valid_m), 32'd1);
        sel = 2'd1;
        tick();
        check("man.dout_sel1", 32'(dout_m), 32'd0);
        check("man.ch_sel1", 32'(ch_m), 32'd1);

        // Out-of-range select on the 3-channel instance.
        sel = 2'd3;
        tick();
        check("oor.dout", 32'(dout_r), 32'd0);
        check("oor.valid", 32'(valid_r), 32'd0);
        check("oor.ch_held", 32'(ch_r), 32'd1);

        // Scan, DWELL=1.
        mode = 1'b1;
        tick();
        check("scan1.turn_valid", 32'(valid_a), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("scan1.dout%0d", i), 32'(dout_a), 32'(seq[i % 4]));
            check($sformatf("scan1.valid%0d", i), 32'(valid_a), 32'd1);
            check($sformatf("scan1.wrap%0d", i), 32'(wrap_a), (i == 3) ? 32'd1 : 32'd0);
        end

        // Scan, DWELL=3: full pass.
        mode = 1'b0;
        tick();
        mode = 1'b1;
        tick();
        check("scan3.turn_valid", 32'(valid_b), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("scan3.dout%0d", i), 32'(dout_b), 32'(seq[i / 3]));
            check($sformatf("scan3.wrap%0d", i), 32'(wrap_b), (i == 11) ? 32'd1 : 32'd0);
        end

        // Enable stall after the second B1 of the next pass.
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall.pre%0d", i), 32'(dout_b), 32'(seq[i / 3]));
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("stall.valid%0d", i), 32'(valid_b), 32'd0);
            check($sformatf("stall.dout%0d", i), 32'(dout_b), 32'hB1);
        end
        en = 1'b1;
        tick();
        check("stall.third_b1", 32'(dout_b), 32'hB1);
        check("stall.third_valid", 32'(valid_b), 32'd1);
        tick();
        check("stall.c2", 32'(dout_b), 32'hC2);

        // Asynchronous reset mid-scan with the DWELL=1 pointer at channel 2.
        mode = 1'b0;
        tick();
        mode = 1'b1;
        tick();
        tick();
        tick();
        check("areset.pre_dout", 32'(dout_a), 32'hB1);
        #2 rst_n = 1'b0;
        mdl_reset();
        #1;
        check("areset.dout", 32'(dout_a), 32'd0);
        check("areset.valid", 32'(valid_a), 32'd0);
        check("areset.ch", 32'(ch_a), 32'd0);
        check("areset.wrap", 32'(wrap_a), 32'd0);
        compare_all();
        #1 rst_n = 1'b1;
        tick();
        check("areset.turn_valid", 32'(valid_a), 32'd0);
        tick();
        check("areset.first_dout", 32'(dout_a), 32'hA0);
        check("areset.first_ch", 32'(ch_a), 32'd0);
        check("areset.first_valid", 32'(valid_a), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            rnd   = $urandom;
            sel   = rnd[1:0];
            din_a = $urandom;
            din_b = $urandom;
            rnd   = $urandom;
            din_m = rnd[3:0];
            din_r = rnd[15:4];
            tick();
            if ($urandom_range(0, 59) == 0) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
